// File: rtl/wave_readout.sv
// wave_readout: drains one half of the double-buffered sample RAM per display
// frame and streams (prev, curr) sample pairs to the line renderer.
module wave_readout #(
    parameter int IDX_W    = 8,
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                read_index,
    output logic [IDX_W:0]      read_address,
    input  logic [SAMPLE_W-1:0] read_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_x,
    output logic [SAMPLE_W-1:0] out_prev,
    output logic [SAMPLE_W-1:0] out_curr,
    output logic                out_last,
    output logic                wave_display_idle
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] X_MAX = '1;

    state_t         state;
    logic           buf_sel;
    logic [IDX_W-1:0] x;

    // The RAM address always comes straight from the latched half and index.
    assign read_address = {buf_sel, x};

    // Sweep sequencer: fetch, capture and present one pair per index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            buf_sel           <= 1'b0;
            x                 <= '0;
            out_valid         <= 1'b0;
            out_x             <= '0;
            out_prev          <= '0;
            out_curr          <= '0;
            out_last          <= 1'b0;
            wave_display_idle <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        // The half is frozen here; capture may flip read_index
                        // freely once the sweep is running.
                        buf_sel           <= read_index;
                        x                 <= '0;
                        state             <= FETCH;
                        wave_display_idle <= 1'b0;
                    end
                end
                FETCH: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    out_curr  <= read_value;
                    // out_curr still holds sample x-1; the first pair of a
                    // sweep has no predecessor, so it repeats itself.
                    out_prev  <= (x == '0) ? read_value : out_curr;
                    out_x     <= x;
                    out_last  <= (x == X_MAX);
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (x == X_MAX) begin
                            state             <= IDLE;
                            wave_display_idle <= 1'b1;
                        end else begin
                            x     <= x + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state             <= IDLE;
                    wave_display_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_readout.sv
// Directed bench for wave_readout with a registered 512x8 RAM model.
module tb_wave_readout;

    localparam int IDX_W    = 8;
    localparam int SAMPLE_W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                frame_start;
    logic                read_index;
    logic [IDX_W:0]      read_address;
    logic [SAMPLE_W-1:0] read_value;
    logic                out_valid;
    logic                out_ready;
    logic [IDX_W-1:0]    out_x;
    logic [SAMPLE_W-1:0] out_prev;
    logic [SAMPLE_W-1:0] out_curr;
    logic                out_last;
    logic                wave_display_idle;

    logic [7:0] mem [512];

    int vecs = 0;
    int errs = 0;

    wave_readout #(.IDX_W(IDX_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_start       (frame_start),
        .read_index        (read_index),
        .read_address      (read_address),
        .read_value        (read_value),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_x             (out_x),
        .out_prev          (out_prev),
        .out_curr          (out_curr),
        .out_last          (out_last),
        .wave_display_idle (wave_display_idle)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears one cycle after the address.
    always @(posedge clk) read_value <= mem[read_address];

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse frame_start, then follow the sweep checking every pair.
    // stall_at / disturb_at / reset_at select the index where the extra
    // action happens (-1 = never).
    task automatic run_sweep(input logic sel, input int stall_at, input int disturb_at,
                             input int reset_at, output int hs, output int idle_lo);
        int         cyc;
        logic       fs_clear;
        logic       done;
        logic [8:0] ea;
        logic [7:0] e_prev;
        logic [31:0] s_x, s_p, s_c, s_a;
        hs = 0;
        idle_lo = 0;
        fs_clear = 1'b0;
        done = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); @(negedge clk);
        frame_start = 1'b0;
        for (cyc = 0; cyc < 2000 && !done; cyc++) begin
            if (fs_clear) begin
                frame_start = 1'b0;
                fs_clear = 1'b0;
            end
            if (wave_display_idle) begin
                done = 1'b1;
            end else begin
                idle_lo++;
                chk("addr_half", 32'(read_address[IDX_W]), 32'(sel));
                if (out_valid) begin
                    if (hs == reset_at) begin
                        reset = 1'b1;
                        @(posedge clk); @(negedge clk);
                        reset = 1'b0;
                        chk("rst_mid_valid", 32'(out_valid), 32'd0);
                        chk("rst_mid_idle", 32'(wave_display_idle), 32'd1);
                        chk("rst_mid_addr", 32'(read_address), 32'd0);
                        return;
                    end
                    ea = {sel, 8'(hs)};
                    e_prev = (hs == 0) ? mem[ea] : mem[ea - 9'd1];
                    chk("pair_x", 32'(out_x), 32'(hs));
                    chk("pair_curr", 32'(out_curr), 32'(mem[ea]));
                    chk("pair_prev", 32'(out_prev), 32'(e_prev));
                    chk("pair_last", 32'(out_last), 32'(hs == 255));
                    chk("pair_addr", 32'(read_address), 32'(ea));
                    if (hs == stall_at) begin
                        out_ready = 1'b0;
                        s_x = 32'(out_x);
                        s_p = 32'(out_prev);
                        s_c = 32'(out_curr);
                        s_a = 32'(read_address);
                        for (int k = 0; k < 5; k++) begin
                            @(posedge clk); @(negedge clk);
                            idle_lo++;
                            chk("stall_valid", 32'(out_valid), 32'd1);
                            chk("stall_x", 32'(out_x), s_x);
                            chk("stall_prev", 32'(out_prev), s_p);
                            chk("stall_curr", 32'(out_curr), s_c);
                            chk("stall_addr", 32'(read_address), s_a);
                        end
                        out_ready = 1'b1;
                    end
                    if (hs == disturb_at) begin
                        read_index = ~read_index;
                        frame_start = 1'b1;
                        fs_clear = 1'b1;
                    end
                    hs++;
                end
                @(posedge clk); @(negedge clk);
            end
        end
        frame_start = 1'b0;
        if (!done) chk("sweep_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int hs;
        int il;
        reset       = 1'b1;
        frame_start = 1'b0;
        read_index  = 1'b0;
        out_ready   = 1'b1;
        for (int a = 0; a < 512; a++) mem[a] = 8'(a) ^ 8'h5A;

        // Reset held for two cycles
        @(negedge clk);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_idle", 32'(wave_display_idle), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", 32'(read_address), 32'd0);
        chk("rst_x", 32'(out_x), 32'd0);
        chk("rst_prev", 32'(out_prev), 32'd0);
        chk("rst_curr", 32'(out_curr), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_idle", 32'(wave_display_idle), 32'd1);

        // Full sweep of the upper half with the renderer always ready
        read_index = 1'b1;
        run_sweep(1'b1, -1, -1, -1, hs, il);
        chk("sweep_handshakes", 32'(hs), 32'd256);
        chk("sweep_busy_cycles", 32'(il), 32'd768);
        chk("sweep_end_valid", 32'(out_valid), 32'd0);
        chk("first_pair_val", 32'(mem[9'h100]), 32'h5A);

        // Back-pressure for five cycles at x=10
        run_sweep(1'b1, 10, -1, -1, hs, il);
        chk("stall_handshakes", 32'(hs), 32'd256);
        chk("stall_busy_cycles", 32'(il), 32'd773);

        // read_index toggle and stray frame_start at x=40 are ignored
        run_sweep(1'b1, -1, 40, -1, hs, il);
        chk("disturb_handshakes", 32'(hs), 32'd256);
        chk("disturb_busy_cycles", 32'(il), 32'd768);
        read_index = 1'b1;

        // Reset in the middle of a sweep, then a clean restart
        run_sweep(1'b1, -1, -1, 100, hs, il);
        chk("rst_sweep_hs", 32'(hs), 32'd100);
        @(posedge clk); @(negedge clk);
        chk("rst_sweep_still_idle", 32'(wave_display_idle), 32'd1);
        run_sweep(1'b1, -1, -1, -1, hs, il);
        chk("restart_handshakes", 32'(hs), 32'd256);

        // Reset and frame_start together: reset wins
        reset = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        frame_start = 1'b0;
        chk("rst_fs_idle", 32'(wave_display_idle), 32'd1);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_fs_stay_idle", 32'(wave_display_idle), 32'd1);
        chk("rst_fs_valid", 32'(out_valid), 32'd0);
        chk("rst_fs_addr", 32'(read_address), 32'd0);

        // Capture side refills the lower half, then flips read_index
        for (int a = 0; a < 256; a++) mem[a] = 8'(a * 3 + 7);
        read_index = 1'b0;
        run_sweep(1'b0, -1, -1, -1, hs, il);
        chk("cosim_handshakes", 32'(hs), 32'd256);
        chk("cosim_idle", 32'(wave_display_idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
